pixel_stream_unpacker: RTL and testbench
========================================

PIXEL_STREAM_UNPACKER -- requirements
Module: pixel_stream_unpacker

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port hard_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port sof, input, 1 bit: synchronous start-of-frame resynchronisation pulse.
REQ-007 Port byte_in, input, 8 bits: stream byte; high byte is {4'b0, R[3:0]}, low byte is {G[3:0], B[3:0]}.
REQ-008 Port byte_valid, input, 1 bit: byte_in holds a valid byte.
REQ-009 Port byte_ready, output, 1 bit: block accepts byte_in this cycle.
REQ-010 Port pixel, output, 12 bits: assembled pixel {R, G, B}.
REQ-011 Port pixel_x, output, 10 bits: column of the presented pixel.
REQ-012 Port pixel_y, output, 10 bits: row of the presented pixel.
REQ-013 Port pixel_valid, output, 1 bit: pixel, pixel_x and pixel_y are valid.
REQ-014 Port pixel_ready, input, 1 bit: downstream accepts the pixel.
REQ-015 Port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.
REQ-016 Port err_count, output, 8 bits: count of protocol errors, saturating.

Function
REQ-017 A byte handshake SHALL occur when byte_valid and byte_ready are both high; a pixel handshake SHALL occur when pixel_valid and pixel_ready are both high.
REQ-018 FSM states: S_HI (await high byte), S_LO (await low byte), S_OUT (pixel held).
REQ-019 In S_HI, byte_ready SHALL be 1; a handshake with byte_in[7:4]==0 SHALL latch R=byte_in[3:0] and move to S_LO.
REQ-020 In S_HI, a handshake with byte_in[7:4]!=0 SHALL drop the byte, stay in S_HI, and raise an error event.
REQ-021 In S_LO, byte_ready SHALL be 1; a handshake SHALL latch {G,B}=byte_in and move to S_OUT.
REQ-022 In S_OUT, pixel_valid SHALL be 1, byte_ready SHALL equal pixel_ready, and pixel/pixel_x/pixel_y SHALL stay stable until the pixel handshake.
REQ-023 In S_OUT, a pixel handshake with a simultaneous byte handshake SHALL process that byte per REQ-019/REQ-020; a pixel handshake alone SHALL move to S_HI.
REQ-024 pixel_valid SHALL be registered; latency from the low-byte handshake to pixel_valid high SHALL be 1 cycle.
REQ-025 On each pixel handshake, pixel_x SHALL increment; at H_ACTIVE-1 it SHALL wrap to 0 and pixel_y SHALL increment.
REQ-026 At pixel_x==H_ACTIVE-1 and pixel_y==V_ACTIVE-1, a pixel handshake SHALL wrap both to 0, and frame_done SHALL be 1 on the next cycle only.
REQ-027 sof high SHALL force S_HI, pixel_x=0 and pixel_y=0, and discard any partial or held pixel; sof SHALL take priority over any handshake in the same cycle, and the byte is not consumed.
REQ-028 sof in S_LO or S_OUT SHALL raise an error event; sof in S_HI with pixel_x==pixel_y==0 SHALL NOT.
REQ-029 err_count SHALL increment by 1 per error event and saturate at 255.

Reset
REQ-030 While hard_reset_n is low: state S_HI, byte_ready=0, pixel_valid=0, pixel=0, pixel_x=0, pixel_y=0, frame_done=0, err_count=0.
REQ-031 byte_ready SHALL go to 1 on the first clock edge after hard_reset_n deasserts.
REQ-032 Reset asserted mid-pixel or mid-frame SHALL discard all partial state, with no frame_done pulse.

Configuration
REQ-033 With macro UNPACKER_ERRCNT_EN defined, err_count SHALL behave per REQ-029.
REQ-034 With UNPACKER_ERRCNT_EN undefined, err_count SHALL be constant 0 and no counter logic SHALL exist; error handling (byte drop, resync) SHALL be unchanged.

Verification
REQ-035 Bytes 0x0A, 0x5C with pixel_ready=1 -> pixel=0xA5C, pixel_x=0, pixel_y=0, pixel_valid high 1 cycle after the 0x5C handshake.
REQ-036 Byte 0x3F in S_HI -> byte dropped, err_count=1; following 0x01, 0x23 -> pixel=0x123.
REQ-037 pixel_ready=0 for 5 cycles in S_OUT -> pixel stable, byte_ready=0; when ready rises, a high byte presented is accepted that same cycle.
REQ-038 Full 640x480 frame streamed -> after pixel (639,479) is accepted, frame_done=1 for exactly 1 cycle; next pixel at (0,0).
REQ-039 sof asserted in S_LO at pixel_x=100 -> state S_HI, pixel_x=0, pixel_y=0, err_count incremented, byte that cycle not consumed.
REQ-040 hard_reset_n pulsed low mid-frame -> all outputs at reset values; no frame_done; err_count=0.

Source files
------------

// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker
//
// Purpose: assembles 12-bit RGB444 pixels from a byte stream. Each pixel is
// carried as two bytes: a high byte {4'b0, R} followed by a low byte {G, B}.
// Assembled pixels are presented with their raster coordinates and held until
// the downstream side accepts them. A start-of-frame pulse resynchronises the
// stream and the raster position.
//
// Ports:
//   clk           single clock, rising edge
//   hard_reset_n  asynchronous active-low reset
//   sof           synchronous start-of-frame resync pulse
//   byte_in       stream byte
//   byte_valid    byte_in holds a valid byte
//   byte_ready    byte_in is accepted this cycle
//   pixel         assembled pixel {R, G, B}
//   pixel_x/y     raster column/row of the presented pixel
//   pixel_valid   pixel, pixel_x, pixel_y are valid
//   pixel_ready   downstream accepts the pixel
//   frame_done    one-cycle pulse after the last pixel of a frame is accepted
//   err_count     saturating protocol error count
//   dbg_state     current FSM state (S_HI=0, S_LO=1, S_OUT=2)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and pixel data is held stable
// while pixel_valid is high and pixel_ready is low.
//
// Optional build macro: UNPACKER_ERRCNT_EN. When defined, err_count counts
// protocol errors (malformed high byte, resync mid-pixel or mid-frame) and
// saturates at 255. When undefined, err_count is tied to 0; the error handling
// itself (byte drop, resync) is identical.

module pixel_stream_unpacker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        hard_reset_n,
  input  logic        sof,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [11:0] pixel,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_done,
  output logic [7:0]  err_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_HI  = 2'd0,
    S_LO  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  state_t      state_q, state_d;
  logic        alive_q, alive_d;       // low during reset, high from the first edge after
  logic [3:0]  r_q, r_d;
  logic [11:0] pixel_q, pixel_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        err_event;
  logic        byte_ready_c;
  logic        byte_hs;
  logic        pix_hs;

  always_comb begin
    state_d      = state_q;
    alive_d      = 1'b1;
    r_d          = r_q;
    pixel_d      = pixel_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    err_event    = 1'b0;

    case (state_q)
      S_HI, S_LO: byte_ready_c = alive_q;
      // A new high byte is only taken when the held pixel leaves this cycle.
      S_OUT:      byte_ready_c = alive_q & pixel_ready;
      default:    byte_ready_c = 1'b0;
    endcase
    // sof wins over any handshake, so the byte on the bus is not consumed.
    if (sof) byte_ready_c = 1'b0;

    byte_hs = byte_valid & byte_ready_c;
    pix_hs  = pixel_valid_q & pixel_ready & ~sof;

    if (sof) begin
      state_d   = S_HI;
      x_d       = 10'd0;
      y_d       = 10'd0;
      // A resync is only clean when nothing is partial and the raster is at origin.
      err_event = (state_q != S_HI) || (x_q != 10'd0) || (y_q != 10'd0);
    end else begin
      if (pix_hs) begin
        state_d = S_HI;
        if (x_q == X_LAST) begin
          x_d = 10'd0;
          if (y_q == Y_LAST) begin
            y_d          = 10'd0;
            frame_done_d = 1'b1;
          end else begin
            y_d = y_q + 10'd1;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      if (byte_hs) begin
        if (state_q == S_LO) begin
          pixel_d = {r_q, byte_in};
          state_d = S_OUT;
        end else if (byte_in[7:4] == 4'd0) begin
          // High byte in S_HI, or in S_OUT alongside the pixel handshake.
          r_d     = byte_in[3:0];
          state_d = S_LO;
        end else begin
          err_event = 1'b1;
        end
      end
    end

    pixel_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q       <= S_HI;
      alive_q       <= 1'b0;
      r_q           <= 4'd0;
      pixel_q       <= 12'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      alive_q       <= alive_d;
      r_q           <= r_d;
      pixel_q       <= pixel_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
    end
  end

`ifdef UNPACKER_ERRCNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_event && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) err_q <= 8'd0;
    else               err_q <= err_d;
  end

  assign err_count = err_q;
`else
  logic unused_err_event;
  assign unused_err_event = err_event;
  assign err_count        = 8'd0;
`endif

  assign byte_ready  = byte_ready_c;
  assign pixel       = pixel_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_done  = frame_done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// Testbench for pixel_stream_unpacker. A reduced raster (128x3) keeps a full
// frame short. Inputs are driven 1 time unit after the rising edge, outputs
// are compared on the falling edge, and the reference model advances on the
// rising edge.
module tb_pixel_stream_unpacker;

  localparam int H    = 128;
  localparam int V    = 3;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        hard_reset_n;
  logic        sof;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [11:0] pixel;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        frame_done;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  pixel_stream_unpacker #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .hard_reset_n(hard_reset_n), .sof(sof), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pixel(pixel),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .frame_done(frame_done), .err_count(err_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_seen  = 0;

  // ---------------- reference model ----------------
  // exp_q holds the assembled-but-not-yet-accepted pixel (0 or 1 entries);
  // m_pend/m_r is a red nibble awaiting its low byte; m_pos is the linear
  // raster index of the next pixel to be accepted.
  logic [11:0] exp_q[$];
  bit          m_alive;
  bit          m_pend;
  logic [3:0]  m_r;
  int          m_pos;
  int          m_err;
  bit          m_fd;

  function automatic int exp_err(input int n);
`ifdef UNPACKER_ERRCNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_alive = 1'b0;
    m_pend  = 1'b0;
    m_r     = 4'd0;
    m_pos   = 0;
    m_err   = 0;
    m_fd    = 1'b0;
  endtask

  task automatic add_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_check();
    bit pv;
    bit br;
    pv = (exp_q.size() != 0);
    br = m_alive && !sof && (!pv || pixel_ready);
    check("byte_ready", byte_ready, br);
    check("pixel_valid", pixel_valid, pv);
    if (pv) begin
      check("pixel", pixel, exp_q[0]);
      check("pixel_x", pixel_x, m_pos % H);
      check("pixel_y", pixel_y, m_pos / H);
    end
    check("frame_done", frame_done, m_fd);
    check("err_count", err_count, exp_err(m_err));
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic model_update();
    bit pv;
    bit br;
    bit phs;
    bit bhs;
    if (!hard_reset_n) begin
      model_reset();
      return;
    end
    pv = (exp_q.size() != 0);
    br = m_alive && !sof && (!pv || pixel_ready);
    m_fd = 1'b0;
    if (sof) begin
      if (m_pend || pv || m_pos != 0) add_err();
      exp_q.delete();
      m_pend = 1'b0;
      m_pos  = 0;
    end else begin
      phs = pv && pixel_ready;
      bhs = byte_valid && br;
      if (phs) begin
        void'(exp_q.pop_front());
        m_fd  = (m_pos == NPIX - 1);
        m_pos = (m_pos + 1) % NPIX;
      end
      if (bhs) begin
        if (m_pend) begin
          exp_q.push_back({m_r, byte_in});
          m_pend = 1'b0;
        end else if (byte_in[7:4] != 4'd0) begin
          add_err();
        end else begin
          m_r    = byte_in[3:0];
          m_pend = 1'b1;
        end
      end
    end
    m_alive = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic [7:0] b, input logic bv, input logic pr);
    sof         = s;
    byte_in     = b;
    byte_valid  = bv;
    pixel_ready = pr;
  endtask

  task automatic cycle(input logic s, input logic [7:0] b, input logic bv, input logic pr);
    drive(s, b, bv, pr);
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic reset_checks();
    check("rst_byte_ready", byte_ready, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel", pixel, 0);
    check("rst_pixel_x", pixel_x, 0);
    check("rst_pixel_y", pixel_y, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_count", err_count, 0);
  endtask

  task automatic do_reset();
    hard_reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h0A, 1'b1, 1'b1);
      @(negedge clk);
      model_check();
      reset_checks();
      @(posedge clk);
      model_update();
      #1;
    end
    hard_reset_n = 1'b1;
    // First cycle after release: byte_ready still low until the next edge.
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Streams n random pixels back to back, then one idle cycle so the last
  // pixel is accepted.
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, {4'h0, 4'($urandom_range(0, 15))}, 1'b1, 1'b1);
      cycle(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        s;
    logic [7:0]  b;
    logic        bv;
    logic        pr;
    logic        e_br;
    logic        e_pv;
    logic [11:0] e_pix;
    int          e_x;
    int          e_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int e0;
    hard_reset_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // 0x0A,0x5C; malformed 0x3F; 0x01,0x23 held 5 cycles; high byte taken
    // in the same cycle the held pixel leaves; then 0x56 completes 0x456.
    vecs[0]  = '{1'b0, 8'h0A, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 0, 0};
    vecs[1]  = '{1'b0, 8'h5C, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 0, 0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 12'hA5C, 0, 0};
    vecs[3]  = '{1'b0, 8'h3F, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1, 0};
    vecs[4]  = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1, 1};
    vecs[5]  = '{1'b0, 8'h23, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1, 1};
    for (int i = 6; i <= 10; i++)
      vecs[i] = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 12'h123, 1, 1};
    vecs[11] = '{1'b0, 8'h04, 1'b1, 1'b1, 1'b1, 1'b1, 12'h123, 1, 1};
    vecs[12] = '{1'b0, 8'h56, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 2, 1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 12'h456, 2, 1};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].s, vecs[i].b, vecs[i].bv, vecs[i].pr);
      @(negedge clk);
      model_check();
      check($sformatf("vec%0d_byte_ready", i), byte_ready, vecs[i].e_br);
      check($sformatf("vec%0d_pixel_valid", i), pixel_valid, vecs[i].e_pv);
      if (vecs[i].e_pv) begin
        check($sformatf("vec%0d_pixel", i), pixel, vecs[i].e_pix);
        check($sformatf("vec%0d_pixel_x", i), pixel_x, vecs[i].e_x);
        check($sformatf("vec%0d_pixel_y", i), pixel_y, 0);
      end
      check($sformatf("vec%0d_err_count", i), err_count, exp_err(vecs[i].e_err));
      @(posedge clk);
      model_update();
      #1;
    end

    // Finish the frame: frame_done pulses once, raster wraps to origin.
    fd_seen = 0;
    stream(NPIX - 3);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("frame_done_pulses", fd_seen, 1);
    check("wrap_pixel_x", pixel_x, 0);
    check("wrap_pixel_y", pixel_y, 0);

    // Clean sof at origin in S_HI: no error, byte not consumed.
    e0 = m_err;
    cycle(1'b1, 8'h0A, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("sof_origin_err", err_count, exp_err(e0));

    // sof in S_LO at pixel_x=100.
    stream(100);
    check("pre_sof_pixel_x", pixel_x, 100);
    cycle(1'b0, 8'h0A, 1'b1, 1'b1);
    e0 = m_err;
    cycle(1'b1, 8'h0B, 1'b1, 1'b1);
    check("sof_lo_pixel_x", pixel_x, 0);
    check("sof_lo_pixel_y", pixel_y, 0);
    check("sof_lo_dbg_state_hi", dbg_state, 0);
    check("sof_lo_err", err_count, exp_err(e0 + 1));
    cycle(1'b0, 8'h01, 1'b1, 1'b1);
    cycle(1'b0, 8'h23, 1'b1, 1'b1);
    check("after_sof_pixel", pixel, 12'h123);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // sof while a pixel is held.
    cycle(1'b0, 8'h07, 1'b1, 1'b0);
    cycle(1'b0, 8'h89, 1'b1, 1'b0);
    cycle(1'b1, 8'h01, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Error counter saturation.
    for (int i = 0; i < 260; i++)
      cycle(1'b0, 8'(8'h10 | 8'($urandom_range(0, 239))), 1'b1, 1'b1);
    check("err_saturated", err_count, exp_err(255));

    // Reset mid-frame with a pixel held at the end of the frame.
    stream(NPIX - 2);
    cycle(1'b0, 8'h0F, 1'b1, 1'b0);
    cycle(1'b0, 8'hFF, 1'b1, 1'b0);
    fd_seen = 0;
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("reset_no_frame_done", fd_seen, 0);
    check("reset_err_cleared", err_count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic       s;
      logic [7:0] b;
      s = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 1) == 0) b = {4'h0, 4'($urandom_range(0, 15))};
      else b = 8'($urandom_range(0, 255)) & 8'h0F | (8'($urandom_range(0, 1)) << 4);
      cycle(s, b, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
